// File: rtl/i2c_slave.sv
// I2C target: oversamples SCL/SDA, matches a 7-bit address, ACKs received bytes
// and shifts out user-supplied bytes on reads. SDA is open drain, SCL input only.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [SYNC_N-1:0] scl_pipe, sda_pipe;
    logic              scl_hist, sda_hist;
    logic              scl_s, sda_s;
    logic              scl_rise, scl_fall, start_evt, stop_evt;
    logic              addr_match;

    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic       sda_oe, sda_oe_nxt;
    logic [7:0] rx_data_nxt;
    logic       rw_nxt, busy_nxt;
    logic       rx_valid_nxt, tx_req_nxt, start_det_nxt, stop_det_nxt;

    // Reset asserts immediately but leaves on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Identical pipelines on both lines keep SCL/SDA event ordering intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_N-2:0], scl};
            sda_pipe <= {sda_pipe[SYNC_N-2:0], sda};
            scl_hist <= scl_pipe[SYNC_N-1];
            sda_hist <= sda_pipe[SYNC_N-1];
        end
    end

    assign scl_s      = scl_pipe[SYNC_N-1];
    assign sda_s      = sda_pipe[SYNC_N-1];
    assign scl_rise   = scl_s & ~scl_hist;
    assign scl_fall   = ~scl_s & scl_hist;
    assign start_evt  = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop_evt   = scl_s & scl_hist & ~sda_hist & sda_s;
    assign addr_match = (shift[7:1] == SLAVE_ADDR);

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            sda_oe    <= sda_oe_nxt;
            rx_data   <= rx_data_nxt;
            rw        <= rw_nxt;
            busy      <= busy_nxt;
            rx_valid  <= rx_valid_nxt;
            tx_req    <= tx_req_nxt;
            start_det <= start_det_nxt;
            stop_det  <= stop_det_nxt;
        end
    end

    // In ACK states bit_cnt == 1 marks that the 9th rising edge has been seen.
    always_comb begin
        state_nxt = state;
        if (stop_evt) begin
            state_nxt = IDLE;
        end else if (start_evt) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                ADDR: begin
                    if (scl_fall && bit_cnt == 4'd8)
                        state_nxt = addr_match ? ADDR_ACK : WAIT_STOP;
                end
                ADDR_ACK: begin
                    if (scl_fall && bit_cnt == 4'd1)
                        state_nxt = rw ? TX_BYTE : RX_BYTE;
                end
                RX_BYTE: begin
                    if (scl_fall && bit_cnt == 4'd8) state_nxt = RX_ACK;
                end
                RX_ACK: begin
                    if (scl_fall && bit_cnt == 4'd1) state_nxt = RX_BYTE;
                end
                TX_BYTE: begin
                    if (scl_fall && bit_cnt == 4'd8) state_nxt = TX_ACK;
                end
                TX_ACK: begin
                    if (scl_rise && sda_s)
                        state_nxt = WAIT_STOP;
                    else if (scl_fall && bit_cnt == 4'd1)
                        state_nxt = TX_BYTE;
                end
                WAIT_STOP: state_nxt = WAIT_STOP;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        sda_oe_nxt    = sda_oe;
        rx_data_nxt   = rx_data;
        rw_nxt        = rw;
        busy_nxt      = busy;
        rx_valid_nxt  = 1'b0;
        tx_req_nxt    = 1'b0;
        start_det_nxt = 1'b0;
        stop_det_nxt  = 1'b0;
        if (stop_evt) begin
            sda_oe_nxt   = 1'b0;
            stop_det_nxt = 1'b1;
            busy_nxt     = 1'b0;
            rw_nxt       = 1'b0;
            bit_cnt_nxt  = '0;
        end else if (start_evt) begin
            sda_oe_nxt    = 1'b0;
            start_det_nxt = 1'b1;
            busy_nxt      = 1'b0;
            bit_cnt_nxt   = '0;
        end else begin
            case (state)
                ADDR, RX_BYTE: begin
                    if (scl_rise) begin
                        shift_nxt   = {shift[6:0], sda_s};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (state == RX_BYTE && bit_cnt == 4'd7) begin
                            rx_data_nxt  = {shift[6:0], sda_s};
                            rx_valid_nxt = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nxt = '0;
                        if (state == RX_BYTE) begin
                            sda_oe_nxt = 1'b1;
                        end else if (addr_match) begin
                            sda_oe_nxt = 1'b1;
                            rw_nxt     = shift[0];
                            busy_nxt   = 1'b1;
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = 4'd1;
                        tx_req_nxt  = (state == ADDR_ACK) && rw;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        bit_cnt_nxt = '0;
                        if (state == ADDR_ACK && rw) begin
                            shift_nxt  = tx_data;
                            sda_oe_nxt = ~tx_data[7];
                        end else begin
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt_nxt = '0;
                            sda_oe_nxt  = 1'b0;
                        end else begin
                            shift_nxt  = {shift[6:0], 1'b0};
                            sda_oe_nxt = ~shift[6];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_nxt  = 1'b1;
                            bit_cnt_nxt = 4'd1;
                        end else begin
                            busy_nxt = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        bit_cnt_nxt = '0;
                        shift_nxt   = tx_data;
                        sda_oe_nxt  = ~tx_data[7];
                    end
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master with transaction-level
// expectations (address hit, ACKs, received and transmitted bytes).
module tb_i2c_slave;

    localparam logic [6:0] SLAVE_ADDR = 7'h42;
    localparam int         Q          = 8;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, rw, busy, start_det, stop_det;

    int checks = 0;
    int failures = 0;
    int rx_valid_cnt = 0, tx_req_cnt = 0, start_cnt = 0, stop_cnt = 0;
    int viol_cnt = 0, drv_cnt = 0;
    logic       dut_drv_prev = 1'b0;
    logic [7:0] exp_rx_data = 8'h00;
    logic [7:0] got_rx[$];
    logic [7:0] tx_q[$];
    logic [7:0] wr_q[$];

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl       (scl_drv),
        .sda       (sda),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .rw        (rw),
        .busy      (busy),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always #5 clk = ~clk;

    // Pulse counters, received bytes, the tx_data supplier and a check that
    // the target never changes its SDA drive while SCL is high.
    always @(posedge clk) begin
        logic dut_now;
        #2;
        dut_now = (sda === 1'b0) && !m_low;
        if (reset_n && scl_drv && (dut_now != dut_drv_prev)) viol_cnt++;
        if (dut_now) drv_cnt++;
        dut_drv_prev = dut_now;
        if (rx_valid) begin
            rx_valid_cnt++;
            got_rx.push_back(rx_data);
        end
        if (tx_req) begin
            tx_req_cnt++;
            if (tx_q.size() > 0) tx_data = tx_q.pop_front();
        end
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (scl_drv == 1'b0) begin
            m_low = 1'b0;
            wait_clks(Q);
            scl_drv = 1'b1;
            wait_clks(2 * Q);
        end
        m_low = 1'b1;
        wait_clks(2 * Q);
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(2 * Q);
        m_low = 1'b0;
        wait_clks(2 * Q);
    endtask

    task automatic clock_bit(input logic drive_bit, output logic sampled);
        m_low = !drive_bit;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        sampled = sda;
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = !s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(!master_ack, s);
    endtask

    // Write transfer of the bytes in wr_q to address byte addr.
    task automatic write_xfer(input logic [7:0] addr);
        logic ack;
        bit   hit;
        int   rxv0, st0, sp0, drv0;
        hit  = (addr[7:1] == SLAVE_ADDR) && !addr[0];
        got_rx.delete();
        rxv0 = rx_valid_cnt;
        st0  = start_cnt;
        sp0  = stop_cnt;
        drv0 = drv_cnt;
        bus_start();
        write_byte(addr, ack);
        check_output("wr_addr_ack", 32'(ack), 32'(hit));
        check_output("wr_busy_after_addr", 32'(busy), 32'(hit));
        foreach (wr_q[i]) begin
            write_byte(wr_q[i], ack);
            check_output("wr_data_ack", 32'(ack), 32'(hit));
            if (hit) exp_rx_data = wr_q[i];
        end
        check_output("wr_busy_before_stop", 32'(busy), 32'(hit));
        check_output("wr_rw", 32'(rw), 32'(0));
        bus_stop();
        check_output("wr_busy_after_stop", 32'(busy), 32'(0));
        check_output("wr_rx_valid_count", rx_valid_cnt - rxv0, hit ? wr_q.size() : 0);
        if (hit) begin
            foreach (wr_q[i])
                if (i < got_rx.size()) check_output("wr_rx_byte", 32'(got_rx[i]), 32'(wr_q[i]));
        end
        check_output("wr_rx_data", 32'(rx_data), 32'(exp_rx_data));
        check_output("wr_start_det_count", start_cnt - st0, 1);
        check_output("wr_stop_det_count", stop_cnt - sp0, 1);
        check_output("wr_sda_driven", 32'(drv_cnt != drv0), 32'(hit));
    endtask

    // Read transfer of nbytes; bytes come from tx_q, last byte NACKed.
    task automatic read_xfer(input logic [7:0] addr, input int nbytes);
        logic       ack;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        bit         hit;
        int         treq0, sp0;
        hit   = (addr[7:1] == SLAVE_ADDR) && addr[0];
        exp_q = tx_q;
        treq0 = tx_req_cnt;
        sp0   = stop_cnt;
        bus_start();
        write_byte(addr, ack);
        check_output("rd_addr_ack", 32'(ack), 32'(hit));
        check_output("rd_rw", 32'(rw), 32'(hit));
        check_output("rd_busy_after_addr", 32'(busy), 32'(hit));
        for (int i = 0; i < nbytes; i++) begin
            read_byte(i != nbytes - 1, b);
            check_output("rd_byte", 32'(b), hit ? 32'(exp_q[i]) : 32'hFF);
        end
        check_output("rd_tx_req_count", tx_req_cnt - treq0, hit ? nbytes : 0);
        check_output("rd_busy_after_nack", 32'(busy), 32'(0));
        bus_stop();
        check_output("rd_stop_det_count", stop_cnt - sp0, 1);
        check_output("rd_rw_after_stop", 32'(rw), 32'(0));
        tx_q.delete();
    endtask

    initial begin
        logic       ack, s;
        logic [7:0] b, addr_w;
        int         st0, sp0, rxv0, n;
        logic [6:0] a7;

        reset_n = 1'b0;
        wait_clks(4);
        check_output("rst_rx_data", 32'(rx_data), 32'(0));
        check_output("rst_rx_valid", 32'(rx_valid), 32'(0));
        check_output("rst_tx_req", 32'(tx_req), 32'(0));
        check_output("rst_rw", 32'(rw), 32'(0));
        check_output("rst_busy", 32'(busy), 32'(0));
        check_output("rst_start_det", 32'(start_det), 32'(0));
        check_output("rst_stop_det", 32'(stop_det), 32'(0));
        check_output("rst_sda", 32'(sda), 32'(1));
        reset_n = 1'b1;
        wait_clks(6);

        $display("[TB] write transfer");
        wr_q = '{8'h5A};
        write_xfer(8'h84);

        $display("[TB] address mismatch");
        wr_q = '{8'h11};
        write_xfer(8'h86);

        $display("[TB] read transfer");
        tx_q = '{8'hA5, 8'h3C};
        read_xfer(8'h85, 2);

        $display("[TB] repeated start");
        st0  = start_cnt;
        sp0  = stop_cnt;
        rxv0 = rx_valid_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check_output("sr_addr1_ack", 32'(ack), 32'(1));
        write_byte(8'h10, ack);
        check_output("sr_data_ack", 32'(ack), 32'(1));
        exp_rx_data = 8'h10;
        check_output("sr_rw_write", 32'(rw), 32'(0));
        tx_q = '{8'($urandom)};
        b = tx_q[0];
        bus_start();
        write_byte(8'h85, ack);
        check_output("sr_addr2_ack", 32'(ack), 32'(1));
        check_output("sr_rw_read", 32'(rw), 32'(1));
        addr_w = b;
        read_byte(1'b0, b);
        check_output("sr_read_byte", 32'(b), 32'(addr_w));
        bus_stop();
        check_output("sr_start_det_count", start_cnt - st0, 2);
        check_output("sr_stop_det_count", stop_cnt - sp0, 1);
        check_output("sr_rx_valid_count", rx_valid_cnt - rxv0, 1);
        check_output("sr_rx_data", 32'(rx_data), 32'(exp_rx_data));
        tx_q.delete();

        $display("[TB] abort mid-byte");
        rxv0 = rx_valid_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check_output("abort_addr_ack", 32'(ack), 32'(1));
        for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), s);
        bus_stop();
        check_output("abort_rx_valid_count", rx_valid_cnt - rxv0, 0);
        check_output("abort_rx_data", 32'(rx_data), 32'(exp_rx_data));
        check_output("abort_busy", 32'(busy), 32'(0));
        wr_q = '{8'($urandom)};
        write_xfer(8'h84);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 6; t++) begin
            a7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLAVE_ADDR;
            n  = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                wr_q.delete();
                for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom));
                write_xfer({a7, 1'b0});
            end else begin
                tx_q.delete();
                for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
                read_xfer({a7, 1'b1}, n);
            end
        end

        check_output("sda_change_while_scl_high", viol_cnt, 0);

        $display("[TB] reset during ACK");
        addr_w = 8'h84;
        bus_start();
        for (int i = 7; i >= 0; i--) clock_bit(addr_w[i], s);
        m_low = 1'b0;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        check_output("mid_ack_sda_low", 32'(sda), 32'(0));
        check_output("mid_ack_busy", 32'(busy), 32'(1));
        reset_n = 1'b0;
        #1;
        check_output("reset_sda_released", 32'(sda), 32'(1));
        check_output("reset_busy", 32'(busy), 32'(0));
        check_output("reset_rw", 32'(rw), 32'(0));
        check_output("reset_rx_data", 32'(rx_data), 32'(0));
        check_output("reset_pulses", {28'd0, rx_valid, tx_req, start_det, stop_det}, 32'(0));
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
        reset_n = 1'b1;
        wait_clks(Q);
        bus_stop();
        check_output("post_reset_busy", 32'(busy), 32'(0));
        check_output("post_reset_sda", 32'(sda), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
